// File: rtl/ac_pkg.sv
// Shared opcode encoding, FSM state and flag types for the accumulator unit.
package ac_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INC  = 4'd4,
    OP_DEC  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_CLR  = 4'd12,
    OP_MUL  = 4'd13
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/ac_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module ac_mul_seq
  import ac_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic             done,
  output logic             last_c,
  output logic [WIDTH-1:0] result_c,
  output logic             ovf_c
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_nxt;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // The final iteration's sum is forwarded so the result lands on the same edge.
  assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
  assign busy     = (state == ST_RUN);
  assign last_c   = (state == ST_RUN) && (cnt == CNT_W'(1));
  assign result_c = prod_nxt[WIDTH-1:0];
  assign ovf_c    = |prod_nxt[PW-1:WIDTH];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= PW'(mcand_in);
            mplier <= mplier_in;
            prod   <= '0;
            cnt    <= CNT_W'(WIDTH);
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ac_unit.sv
// Accumulator: opcode decode, single-cycle ALU, status flags and multiply write-back.
module ac_unit
  import ac_pkg::*;
#(
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       op,
  input  logic             re,
  output logic [WIDTH-1:0] out1,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  op_t              opc;
  flags_t           flags;
  flags_t           nflags;
  logic             accept;
  logic             mul_start;
  logic             mul_last;
  logic             mul_ovf;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             wr;

  assign opc       = op_t'(op);
  assign accept    = re && !busy;
  assign mul_start = accept && (opc == OP_MUL);

  // INC/DEC share the adder and subtractor with a constant operand of one.
  assign opnd = ((opc == OP_INC) || (opc == OP_DEC)) ? WIDTH'(1) : in1;
  assign sum  = {1'b0, out1} + {1'b0, opnd};
  assign dif  = {1'b0, out1} - {1'b0, opnd};

  always_comb begin
    res    = out1;
    nflags = '0;
    wr     = accept;
    case (opc)
      OP_LOAD: res = in1;
      OP_ADD, OP_INC: begin
        res      = sum[WIDTH-1:0];
        nflags.c = sum[WIDTH];
        nflags.v = (out1[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != out1[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        res      = dif[WIDTH-1:0];
        nflags.c = dif[WIDTH];
        nflags.v = (out1[WIDTH-1] != opnd[WIDTH-1]) && (dif[WIDTH-1] != out1[WIDTH-1]);
      end
      OP_AND: res = out1 & in1;
      OP_OR:  res = out1 | in1;
      OP_XOR: res = out1 ^ in1;
      OP_NOT: res = ~out1;
      OP_SHL: begin
        res      = {out1[WIDTH-2:0], 1'b0};
        nflags.c = out1[WIDTH-1];
      end
      OP_SHR: begin
        res      = {1'b0, out1[WIDTH-1:1]};
        nflags.c = out1[0];
      end
      OP_CLR: res = '0;
      default: wr = 1'b0;  // NOP, MUL start and undefined opcodes leave state alone
    endcase
    // Multiply completion only occurs while busy, so it never collides with an accepted op.
    if (mul_last) begin
      res      = mul_res;
      nflags.c = mul_ovf;
      nflags.v = 1'b0;
      wr       = 1'b1;
    end
    nflags.z = (res == '0);
    nflags.n = res[WIDTH-1];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      out1  <= '0;
      flags <= '0;
    end else if (wr) begin
      out1  <= res;
      flags <= nflags;
    end
  end

  assign flag_z = flags.z;
  assign flag_c = flags.c;
  assign flag_n = flags.n;
  assign flag_v = flags.v;

  ac_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .clear     (clear),
    .start     (mul_start),
    .mcand_in  (out1),
    .mplier_in (in1),
    .busy      (busy),
    .done      (done),
    .last_c    (mul_last),
    .result_c  (mul_res),
    .ovf_c     (mul_ovf)
  );

endmodule

// File: tb/tb_ac_unit.sv
// Directed bench for ac_unit at WIDTH=10: vector table plus multiply/reset sequences.
module tb_ac_unit;
  import ac_pkg::*;

  logic       clk;
  logic       clear;
  logic [9:0] in1;
  logic [3:0] op;
  logic       re;
  logic [9:0] out1;
  logic       busy;
  logic       done;
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;
  logic       flag_v;

  int n_cmp = 0;
  int n_bad = 0;

  ac_unit #(.WIDTH(10)) dut (
    .clk    (clk),
    .clear  (clear),
    .in1    (in1),
    .op     (op),
    .re     (re),
    .out1   (out1),
    .busy   (busy),
    .done   (done),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_n (flag_n),
    .flag_v (flag_v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // flags packed {z,c,n,v}; cv=0 means C/V are not checked (LOAD leaves them unspecified)
  typedef struct {
    logic       re;
    logic [3:0] op;
    logic [9:0] in1;
    logic [9:0] out1;
    logic [3:0] f;
    logic       cv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] o, input logic [9:0] d);
    re  = r;
    op  = o;
    in1 = d;
    @(posedge clk);
    #1;
    re  = 1'b0;
    op  = 4'd0;
  endtask

  task automatic run_mul(input logic [9:0] a, input logic [9:0] b, input logic [9:0] exp,
                         input logic ec, input logic inject, input logic load3);
    step(1'b1, OP_LOAD, a);
    step(1'b1, OP_MUL, b);
    chk("mul accept busy", 32'(busy), 32'd1);
    chk("mul accept out1", 32'(out1), 32'(a));
    for (int i = 1; i <= 10; i++) begin
      if (inject && i == 4) begin
        re  = 1'b1;
        op  = OP_LOAD;
        in1 = 10'd7;
      end
      @(posedge clk);
      #1;
      re = 1'b0;
      op = 4'd0;
      if (i < 10) begin
        chk($sformatf("mul run%0d busy", i), 32'(busy), 32'd1);
        chk($sformatf("mul run%0d done", i), 32'(done), 32'd0);
        chk($sformatf("mul run%0d out1", i), 32'(out1), 32'(a));
      end else begin
        chk("mul end busy", 32'(busy), 32'd0);
        chk("mul end done", 32'(done), 32'd1);
        chk("mul end out1", 32'(out1), 32'(exp));
        chk("mul end flags", 32'({flag_z, flag_c, flag_n, flag_v}),
            32'({exp == 10'd0, ec, exp[9], 1'b0}));
      end
    end
    if (load3) step(1'b1, OP_LOAD, 10'd3);
    else       step(1'b0, OP_NOP, 10'd0);
    chk("mul after done", 32'(done), 32'd0);
    chk("mul after out1", 32'(out1), load3 ? 32'd3 : 32'(exp));
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{1'b1, OP_LOAD, 10'd1023,  10'd1023,  4'b0010, 1'b0});
    vt.push_back('{1'b1, OP_ADD,  10'd1,     10'd0,     4'b1100, 1'b1});
    vt.push_back('{1'b1, OP_LOAD, 10'd511,   10'd511,   4'b0000, 1'b0});
    vt.push_back('{1'b1, OP_INC,  10'd0,     10'd512,   4'b0011, 1'b1});
    vt.push_back('{1'b1, OP_LOAD, 10'd0,     10'd0,     4'b1000, 1'b0});
    vt.push_back('{1'b1, OP_SUB,  10'd1,     10'd1023,  4'b0110, 1'b1});
    vt.push_back('{1'b1, OP_NOP,  10'd5,     10'd1023,  4'b0110, 1'b1});
    vt.push_back('{1'b0, OP_LOAD, 10'd5,     10'd1023,  4'b0110, 1'b1});
    vt.push_back('{1'b1, 4'd15,   10'd5,     10'd1023,  4'b0110, 1'b1});
    vt.push_back('{1'b1, OP_LOAD, 10'h201,   10'h201,   4'b0010, 1'b0});
    vt.push_back('{1'b1, OP_SHR,  10'd0,     10'h100,   4'b0100, 1'b1});
    vt.push_back('{1'b1, OP_SHL,  10'd0,     10'h200,   4'b0010, 1'b1});
    vt.push_back('{1'b1, OP_SHL,  10'd0,     10'h000,   4'b1100, 1'b1});
    vt.push_back('{1'b1, OP_DEC,  10'd0,     10'h3FF,   4'b0110, 1'b1});
    vt.push_back('{1'b1, OP_AND,  10'h0F0,   10'h0F0,   4'b0000, 1'b1});
    vt.push_back('{1'b1, OP_OR,   10'h30F,   10'h3FF,   4'b0010, 1'b1});
    vt.push_back('{1'b1, OP_XOR,  10'h0FF,   10'h300,   4'b0010, 1'b1});
    vt.push_back('{1'b1, OP_NOT,  10'd0,     10'h0FF,   4'b0000, 1'b1});
    vt.push_back('{1'b1, OP_LOAD, 10'h200,   10'h200,   4'b0010, 1'b0});
    vt.push_back('{1'b1, OP_SUB,  10'h001,   10'h1FF,   4'b0001, 1'b1});
    vt.push_back('{1'b1, OP_ADD,  10'h001,   10'h200,   4'b0011, 1'b1});
    vt.push_back('{1'b1, OP_ADD,  10'h200,   10'h000,   4'b1101, 1'b1});
    vt.push_back('{1'b1, OP_SUB,  10'h001,   10'h3FF,   4'b0110, 1'b1});
    vt.push_back('{1'b1, OP_CLR,  10'h155,   10'h000,   4'b1000, 1'b1});
    vt.push_back('{1'b1, OP_SUB,  10'h200,   10'h200,   4'b0111, 1'b1});

    clear = 1'b1;
    re    = 1'b0;
    op    = 4'd0;
    in1   = 10'd0;
    #12;
    chk("reset out1", 32'(out1), 32'd0);
    chk("reset flags", 32'({flag_z, flag_c, flag_n, flag_v}), 32'd0);
    chk("reset busy/done", 32'({busy, done}), 32'd0);
    clear = 1'b0;

    // Asynchronous clear lands before the next rising edge
    step(1'b1, OP_LOAD, 10'd5);
    chk("pre-clear out1", 32'(out1), 32'd5);
    #2 clear = 1'b1;
    #1;
    chk("async clear out1", 32'(out1), 32'd0);
    chk("async clear flags", 32'({flag_z, flag_c, flag_n, flag_v}), 32'd0);
    #1 clear = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].re, vt[i].op, vt[i].in1);
      chk($sformatf("vec%0d out1", i), 32'(out1), 32'(vt[i].out1));
      if (vt[i].cv)
        chk($sformatf("vec%0d zcnv", i), 32'({flag_z, flag_c, flag_n, flag_v}), 32'(vt[i].f));
      else
        chk($sformatf("vec%0d zn", i), 32'({flag_z, flag_n}), 32'({vt[i].f[3], vt[i].f[1]}));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
    end

    run_mul(10'd25, 10'd30, 10'd750, 1'b0, 1'b0, 1'b0);
    run_mul(10'd40, 10'd30, 10'd176, 1'b1, 1'b0, 1'b0);
    run_mul(10'd25, 10'd30, 10'd750, 1'b0, 1'b1, 1'b1);

    // Clear in the fifth RUN cycle aborts the multiply without a write-back
    step(1'b1, OP_LOAD, 10'd25);
    step(1'b1, OP_MUL, 10'd30);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("abort pre busy", 32'(busy), 32'd1);
    clear = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out1", 32'(out1), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    #1 clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort idle%0d done", i), 32'({busy, done}), 32'd0);
    end
    chk("abort held out1", 32'(out1), 32'd0);
    step(1'b1, OP_LOAD, 10'd9);
    chk("post-abort load", 32'(out1), 32'd9);
    chk("post-abort flags", 32'({flag_z, flag_n}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
